// File: rtl/servo_sweeper.sv
// Multi-channel servo exerciser: per-channel bounce/wrap position ramps between
// programmable end stops, each driving a registered servo PWM output.
module servo_sweeper #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned POS_W      = 8,
    parameter int unsigned POS_MIN    = 0,
    parameter int unsigned POS_MAX    = 255,
    parameter int unsigned STEP       = 1,
    parameter int unsigned TICK_DIV   = 192000,
    parameter int unsigned DWELL      = 0,
    parameter int unsigned PWM_PERIOD = 240000,
    parameter int unsigned PW_BASE    = 12000,
    parameter int unsigned PW_SCALE   = 47
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      mode,
    output logic                      tick,
    output logic [CHANNELS*POS_W-1:0] pos,
    output logic [CHANNELS-1:0]       dir,
    output logic [CHANNELS-1:0]       servo
);

    localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW   = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int unsigned DW_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam int unsigned PW1  = POS_W + 1;

    logic [TW-1:0]                      r_tcnt;
    logic                               r_tick;
    logic [CW-1:0]                      r_pcnt;
    logic [CHANNELS-1:0][POS_W-1:0]     r_pos;
    logic [CHANNELS-1:0]                r_dir;
    logic [CHANNELS-1:0][DW_W-1:0]      r_dwell;
    logic [CHANNELS-1:0][CW-1:0]        r_width;
    logic [CHANNELS-1:0]                r_servo;

    logic [CHANNELS-1:0][POS_W-1:0]     w_pos_nxt;
    logic [CHANNELS-1:0]                w_dir_nxt;
    logic [CHANNELS-1:0][DW_W-1:0]      w_dwell_nxt;
    logic [CHANNELS-1:0][PW1-1:0]       w_cur;
    logic [CHANNELS-1:0][PW1-1:0]       w_up;
    logic [CHANNELS-1:0][POS_W-1:0]     w_dn;
    logic [CHANNELS-1:0][CW-1:0]        w_width;

    assign tick  = r_tick;
    assign pos   = r_pos;
    assign dir   = r_dir;
    assign servo = r_servo;

    // Sweep tick generator; ena freezes the count without clearing it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (ena) begin
                if (r_tcnt == TW'(TICK_DIV - 1)) begin
                    r_tcnt <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end
        end
    end

    // Next position/direction/dwell per channel; compares are one bit wider than pos
    always_comb begin
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_dwell_nxt = r_dwell;
        w_cur       = '0;
        w_up        = '0;
        w_dn        = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_cur[i] = {1'b0, r_pos[i]};
            w_up[i]  = w_cur[i] + PW1'(STEP);
            w_dn[i]  = r_pos[i] - POS_W'(STEP);
            if (r_dwell[i] != '0) begin
                w_dwell_nxt[i] = r_dwell[i] - DW_W'(1);
            end else if (!mode) begin
                if (r_dir[i]) begin
                    if (w_up[i] >= PW1'(POS_MAX)) begin
                        w_pos_nxt[i]   = POS_W'(POS_MAX);
                        w_dir_nxt[i]   = 1'b0;
                        w_dwell_nxt[i] = DW_W'(DWELL);
                    end else begin
                        w_pos_nxt[i] = w_up[i][POS_W-1:0];
                    end
                end else begin
                    if (w_cur[i] <= PW1'(POS_MIN + STEP)) begin
                        w_pos_nxt[i]   = POS_W'(POS_MIN);
                        w_dir_nxt[i]   = 1'b1;
                        w_dwell_nxt[i] = DW_W'(DWELL);
                    end else begin
                        w_pos_nxt[i] = w_dn[i];
                    end
                end
            end else begin
                if (r_dir[i]) begin
                    if (w_up[i] > PW1'(POS_MAX)) begin
                        w_pos_nxt[i]   = POS_W'(POS_MIN);
                        w_dwell_nxt[i] = DW_W'(DWELL);
                    end else begin
                        w_pos_nxt[i] = w_up[i][POS_W-1:0];
                    end
                end else begin
                    if (w_cur[i] < PW1'(POS_MIN + STEP)) begin
                        w_pos_nxt[i]   = POS_W'(POS_MAX);
                        w_dwell_nxt[i] = DW_W'(DWELL);
                    end else begin
                        w_pos_nxt[i] = w_dn[i];
                    end
                end
            end
            w_width[i] = CW'(PW_BASE) + CW'(CW'(r_pos[i]) * CW'(PW_SCALE));
        end
    end

    // Channel state: even channels start low moving up, odd channels high moving down
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_pos[i] <= (i % 2 == 0) ? POS_W'(POS_MIN) : POS_W'(POS_MAX);
                r_dir[i] <= (i % 2 == 0);
            end
            r_dwell <= '0;
        end else if (r_tick) begin
            r_pos   <= w_pos_nxt;
            r_dir   <= w_dir_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    // Shared PWM frame; width latched at frame start so mid-frame moves cannot glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt  <= '0;
            r_width <= '0;
            r_servo <= '0;
        end else begin
            r_pcnt <= (r_pcnt == CW'(PWM_PERIOD - 1)) ? '0 : r_pcnt + CW'(1);
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (r_pcnt == '0) begin
                    r_width[i] <= w_width[i];
                    r_servo[i] <= (w_width[i] != '0);
                end else begin
                    r_servo[i] <= (r_pcnt < r_width[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_sweeper.sv
// Directed bench for servo_sweeper: table-driven sweep vectors plus hand sequences
// for pause, PWM framing and mid-run reset.
module tb_servo_sweeper;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        mode;
    logic        tick;
    logic [15:0] pos;
    logic [1:0]  dir;
    logic [1:0]  servo;

    int n_cmp;
    int n_err;

    servo_sweeper #(
        .CHANNELS(2), .POS_W(8), .POS_MIN(10), .POS_MAX(20), .STEP(3),
        .TICK_DIV(4), .DWELL(2), .PWM_PERIOD(50), .PW_BASE(5), .PW_SCALE(1)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode),
        .tick(tick), .pos(pos), .dir(dir), .servo(servo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         do_rst;
        bit         md;
        int         p0;
        int         p1;
        logic [1:0] d;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input bit r, input bit m, input int p0, input int p1, input logic [1:0] d);
        vec_t v;
        v.do_rst = r; v.md = m; v.p0 = p0; v.p1 = p1; v.d = d;
        tbl.push_back(v);
    endtask

    task automatic do_reset(input bit m);
        @(negedge clk);
        rst  = 1'b1;
        ena  = 1'b1;
        mode = m;
        @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_servo", servo, 0);
        chk("rst_pos", pos, {8'd20, 8'd10});
        chk("rst_dir", dir, 2'b01);
        rst = 1'b0;
    endtask

    // Negedges waited until tick is seen high; -1 if the budget runs out
    task automatic wait_tick(output int n);
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (tick) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_servo0_rise(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = servo[0];
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (servo[0] && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = servo[0];
        end
    endtask

    initial begin
        int  n;
        int  hi;
        int  lo;
        bit  ok;
        bit  first;
        bit  tk;
        bit  seen;

        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        ena   = 1'b0;
        mode  = 1'b0;

        // Bounce from reset
        add(1, 0, 13, 17, 2'b01); add(0, 0, 16, 14, 2'b01); add(0, 0, 19, 11, 2'b01);
        add(0, 0, 20, 10, 2'b10); add(0, 0, 20, 10, 2'b10); add(0, 0, 20, 10, 2'b10);
        add(0, 0, 17, 13, 2'b10); add(0, 0, 14, 16, 2'b10); add(0, 0, 11, 19, 2'b10);
        add(0, 0, 10, 20, 2'b01); add(0, 0, 10, 20, 2'b01); add(0, 0, 10, 20, 2'b01);
        add(0, 0, 13, 17, 2'b01);
        // Wrap from reset
        add(1, 1, 13, 17, 2'b01); add(0, 1, 16, 14, 2'b01); add(0, 1, 19, 11, 2'b01);
        add(0, 1, 10, 20, 2'b01); add(0, 1, 10, 20, 2'b01); add(0, 1, 10, 20, 2'b01);
        add(0, 1, 13, 17, 2'b01);
        // Bounce to ch0=19 going up, then switch to wrap
        add(1, 0, 13, 17, 2'b01); add(0, 0, 16, 14, 2'b01); add(0, 0, 19, 11, 2'b01);
        add(0, 1, 10, 20, 2'b01); add(0, 1, 10, 20, 2'b01);

        foreach (tbl[i]) begin
            first = 1'b0;
            if (tbl[i].do_rst) begin
                do_reset(tbl[i].md);
                first = 1'b1;
            end
            mode = tbl[i].md;
            wait_tick(n);
            chk($sformatf("v%0d_gap", i), n, first ? 4 : 3);
            @(negedge clk);
            chk($sformatf("v%0d_tick_1cyc", i), tick, 0);
            chk($sformatf("v%0d_pos0", i), pos[7:0], tbl[i].p0);
            chk($sformatf("v%0d_pos1", i), pos[15:8], tbl[i].p1);
            chk($sformatf("v%0d_dir", i), dir, tbl[i].d);
        end

        // Pause for 37 cycles mid-interval
        do_reset(1'b0);
        wait_tick(n);
        chk("pause_first_gap", n, 4);
        @(negedge clk);
        chk("pause_pos_before", pos, {8'd17, 8'd13});
        ena  = 1'b0;
        seen = 1'b0;
        repeat (37) begin
            @(negedge clk);
            if (tick) seen = 1'b1;
        end
        chk("pause_no_tick", seen, 0);
        chk("pause_pos_frozen", pos, {8'd17, 8'd13});
        ena = 1'b1;
        wait_tick(n);
        chk("pause_resume_gap", n, 3);
        @(negedge clk);
        chk("pause_pos_after", pos, {8'd14, 8'd16});
        wait_tick(n);
        chk("pause_next_gap", n, 3);
        @(negedge clk);
        chk("pause_pos_next", pos, {8'd11, 8'd19});

        // PWM: freeze ch0 at 13 for one full frame, move it mid-pulse
        do_reset(1'b0);
        wait_tick(n);
        @(negedge clk);
        chk("pwm_pos13", pos[7:0], 13);
        ena = 1'b0;
        wait_servo0_rise(ok);
        chk("pwm_rise_found", ok, 1);
        ena = 1'b1;
        hi  = 1;
        tk  = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tick) begin
                tk = 1'b1;
            end else if (tk && ena) begin
                ena = 1'b0;
                chk("pwm_midframe_pos", pos[7:0], 16);
            end
            if (servo[0]) hi++;
            else break;
        end
        chk("pwm_width_13", hi, 18);
        lo = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!servo[0]) lo++;
            else break;
        end
        chk("pwm_period", hi + lo, 50);
        hi = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (servo[0]) hi++;
            else break;
        end
        chk("pwm_width_16", hi, 21);

        // Reset during a pulse while both channels are dwelling
        do_reset(1'b0);
        repeat (4) wait_tick(n);
        @(negedge clk);
        chk("rstmid_pre_pos", pos, {8'd10, 8'd20});
        ena = 1'b0;
        wait_servo0_rise(ok);
        chk("rstmid_rise_found", ok, 1);
        chk("rstmid_servo_high", servo[0], 1);
        rst = 1'b1;
        ena = 1'b1;
        @(negedge clk);
        chk("rstmid_servo", servo, 0);
        chk("rstmid_tick", tick, 0);
        chk("rstmid_pos", pos, {8'd20, 8'd10});
        chk("rstmid_dir", dir, 2'b01);
        rst = 1'b0;
        wait_tick(n);
        chk("rstmid_first_tick", n, 4);
        @(negedge clk);
        chk("rstmid_dwell_cleared", pos, {8'd17, 8'd13});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/servo_sweeper.md
# servo_sweeper

Multi-channel servo exerciser that generalises the single-servo sweep test. It produces N independent position ramps between programmable end stops, and drives one servo PWM output per channel.

- Step rate, step size, end-stop dwell and sweep mode (bounce/wrap) are parameters or inputs.
- Odd channels run in antiphase to even channels.
- It sits at the top of servo bring-up designs, directly on the board clock, and drives the servo pins.

## Interface
- CHANNELS, 2, number of servo channels (1..8)
- POS_W, 8, position width in bits
- POS_MIN, 0, lower end stop
- POS_MAX, 255, upper end stop; must satisfy POS_MIN < POS_MAX < 2^POS_W
- STEP, 1, position increment per tick; 1 <= STEP <= POS_MAX-POS_MIN
- TICK_DIV, 192000, clocks per sweep tick (16 ms at 12 MHz)
- DWELL, 0, ticks held at an end stop after arriving or wrapping
- PWM_PERIOD, 240000, clocks per PWM frame (20 ms at 12 MHz)
- PW_BASE, 12000, pulse width in clocks at pos = 0
- PW_SCALE, 47, added clocks per position unit; PW_BASE + (2^POS_W-1)*PW_SCALE must be < PWM_PERIOD
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  sweep enable; 0 freezes the tick counter and all positions (PWM keeps running)
- mode  in  1  0 = bounce (triangle), 1 = wrap (sawtooth)
- tick  out  1  one-cycle pulse per sweep step
- pos  out  CHANNELS*POS_W  channel i position at bits [i*POS_W +: POS_W]
- dir  out  CHANNELS  1 = moving up, 0 = moving down
- servo  out  CHANNELS  PWM outputs

## Operation
- **Reset values**
  - tick = 0, servo = 0, tick counter = 0, PWM counter = 0, all dwell counters = 0.
  - Even channels: pos = POS_MIN, dir = 1. Odd channels: pos = POS_MAX, dir = 0.
- **Tick generator**
  - Counter runs 0..TICK_DIV-1 and advances only when ena = 1.
  - tick is registered and high for exactly one cycle when the counter wraps.
  - ena = 0 holds the counter value; it does not clear it.
- **Per-channel update** on each tick, with channels independent:
  - dwell != 0: decrement dwell; pos and dir unchanged.
  - Bounce, dir = 1: if pos+STEP >= POS_MAX, set pos = POS_MAX, dir = 0, dwell = DWELL; else pos += STEP.
  - Bounce, dir = 0: if pos <= POS_MIN+STEP, set pos = POS_MIN, dir = 1, dwell = DWELL; else pos -= STEP.
  - Wrap, dir = 1: if pos+STEP > POS_MAX, set pos = POS_MIN, dwell = DWELL; else pos += STEP.
  - Wrap, dir = 0: if pos < POS_MIN+STEP, set pos = POS_MAX, dwell = DWELL; else pos -= STEP.
  - dir is never changed in wrap mode.
  - All comparisons use POS_W+1 bits. No overflow or underflow is ever visible on pos.
- **Mode changes**
  - mode is sampled only on tick cycles.
  - A change keeps the current pos, dir and dwell; the next step uses the new rules.
- **PWM**
  - One shared frame counter runs 0..PWM_PERIOD-1 and ignores ena.
  - On the cycle the counter is 0, each channel latches width_i = PW_BASE + pos_i*PW_SCALE.
  - A pos change mid-frame affects only the next frame. No glitches or runt pulses are allowed.
  - servo_i is registered: high while counter < width_i, low otherwise.

## Timing
- tick rises on the edge where the tick counter reaches TICK_DIV-1. Period is TICK_DIV clocks when ena is held at 1.
- pos, dir and dwell update on the clock edge that samples tick = 1, so the new pos is visible the cycle after tick.
- Frame start: servo_i rises on the edge after counter = 0 and stays high exactly width_i cycles. Frame period is exactly PWM_PERIOD cycles.
- rst asserted mid-sweep or mid-pulse: on the next edge all state returns to reset values, and servo drops within 1 cycle.
- rst has priority over ena, mode and tick.
- Latency from ena rising to the first tick: TICK_DIV minus the frozen count value.

## Test plan
Common parameters for all scenarios: CHANNELS=2, POS_MIN=10, POS_MAX=20, STEP=3, TICK_DIV=4, DWELL=2, PWM_PERIOD=50, PW_BASE=5, PW_SCALE=1.

- **Bounce:** mode=0, ena=1 after reset.
  - ch0 pos per tick: 13,16,19,20(dir 0),20,20,17,14,11,10(dir 1),10,10,13.
  - ch1 pos per tick: 17,14,11,10(dir 1),10,10,13.
- **Wrap:** mode=1 after reset.
  - ch0 pos per tick: 13,16,19,10,10,10,13.
  - ch1 pos per tick: 17,14,11,20,20,20,17.
  - dir stays constant on both channels.
- **Pause:** deassert ena for 37 cycles midway through a tick interval.
  - No tick, pos frozen.
  - After ena returns, the next tick arrives after the remaining count, and the sequence resumes unchanged.
- **PWM:** with ch0 pos = 13 latched at frame start:
  - servo0 is high for exactly 18 cycles, starting the cycle after the counter is 0, every 50 cycles.
  - A pos change mid-frame leaves the current pulse at 18 cycles.
- **Mode switch mid-run:** switch bounce to wrap at ch0 pos = 19 with dir=1.
  - The next tick gives pos = 10 with dir unchanged.
- **Reset mid-run:** assert rst for 1 cycle during a servo pulse and dwell.
  - Next cycle: servo = 0, tick = 0, pos = {20,10}, dir = 2'b01.
  - First tick then arrives 4 cycles after rst is released.
